// File: rtl/ae350_reset_sequencer_if.sv
// ae350_reset_sequencer_if: lock/calibration status inputs and reset/status outputs of the
// AE350 reset sequencer. The slave modport is the sequencer side.
interface ae350_reset_sequencer_if;
    logic       pll_lock;
    logic       ddr3_lock;
    logic       ddr3_init_done;
    logic       sw_rst;
    logic       ddr3_rstn;
    logic       por_rstn;
    logic       hw_rstn;
    logic       ready;
    logic       error;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    modport slave (
        input  pll_lock, ddr3_lock, ddr3_init_done, sw_rst,
        output ddr3_rstn, por_rstn, hw_rstn, ready, error, state, retry_cnt
    );

    modport master (
        output pll_lock, ddr3_lock, ddr3_init_done, sw_rst,
        input  ddr3_rstn, por_rstn, hw_rstn, ready, error, state, retry_cnt
    );
endinterface

// File: rtl/ae350_reset_sequencer.sv
// ae350_reset_sequencer: PLL-lock driven bring-up of the DDR3 controller, then AE350 POR/HW resets.
// Define AE350_RSTSEQ_TIMEOUT_EN to add the calibration timeout, retry counting and FAIL state.
module ae350_reset_sequencer #(
    parameter int unsigned LOCK_STABLE     = 16,
    parameter int unsigned DDR_RST_CYCLES  = 1000,
    parameter int unsigned POR_HOLD_CYCLES = 64,
    parameter int unsigned HW_HOLD_CYCLES  = 16,
    parameter int unsigned INIT_TIMEOUT    = 2000000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 24
) (
    input logic                    clk,
    input logic                    rst,
    ae350_reset_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DDR_RST  = 3'd1,
        S_DDR_WAIT = 3'd2,
        S_POR_HOLD = 3'd3,
        S_HW_HOLD  = 3'd4,
        S_RUN      = 3'd5,
        S_FAIL     = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] DDR_LAST  = CNT_W'(DDR_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HW_LAST   = CNT_W'(HW_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       pll_sync_q, ddr_sync_q, init_sync_q;
    logic             lock_ok, init_ok;
    logic             ddr3_rstn_q, por_rstn_q, hw_rstn_q, ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_sync_q  <= '0;
            ddr_sync_q  <= '0;
            init_sync_q <= '0;
        end else begin
            pll_sync_q  <= {pll_sync_q[0], bus.pll_lock};
            ddr_sync_q  <= {ddr_sync_q[0], bus.ddr3_lock};
            init_sync_q <= {init_sync_q[0], bus.ddr3_init_done};
        end
    end

    assign lock_ok = pll_sync_q[1] & ddr_sync_q[1];
    assign init_ok = init_sync_q[1];

    // One shared counter: lock stability in IDLE, dwell/timeout everywhere else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (bus.sw_rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!lock_ok) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = S_DDR_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_FAIL: ;
                default: begin
                    if (!lock_ok || (!init_ok && (state_q == S_POR_HOLD ||
                                                  state_q == S_HW_HOLD  ||
                                                  state_q == S_RUN))) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        case (state_q)
                            S_DDR_RST: begin
                                if (cnt_q == DDR_LAST) begin
                                    state_d = S_DDR_WAIT;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CNT_ONE;
                                end
                            end
                            S_DDR_WAIT: begin
                                if (init_ok) begin
                                    state_d = S_POR_HOLD;
                                    cnt_d   = '0;
                                end
`ifdef AE350_RSTSEQ_TIMEOUT_EN
                                else if (cnt_q == CNT_W'(INIT_TIMEOUT - 1)) begin
                                    retry_d = retry_q + 2'd1;
                                    cnt_d   = '0;
                                    state_d = (retry_d == 2'(MAX_RETRY)) ? S_FAIL : S_DDR_RST;
                                end else begin
                                    cnt_d = cnt_q + CNT_ONE;
                                end
`endif
                            end
                            S_POR_HOLD: begin
                                if (cnt_q == POR_LAST) begin
                                    state_d = S_HW_HOLD;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CNT_ONE;
                                end
                            end
                            S_HW_HOLD: begin
                                if (cnt_q == HW_LAST) begin
                                    state_d = S_RUN;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CNT_ONE;
                                end
                            end
                            S_RUN: ;
                            default: begin
                                state_d = S_IDLE;
                                cnt_d   = '0;
                                retry_d = '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ddr3_rstn_q <= 1'b0;
            por_rstn_q  <= 1'b0;
            hw_rstn_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ddr3_rstn_q <= (state_d == S_DDR_WAIT) || (state_d == S_POR_HOLD) ||
                           (state_d == S_HW_HOLD)  || (state_d == S_RUN);
            por_rstn_q  <= (state_d == S_HW_HOLD) || (state_d == S_RUN);
            hw_rstn_q   <= (state_d == S_RUN);
            ready_q     <= (state_d == S_RUN);
        end
    end

`ifdef AE350_RSTSEQ_TIMEOUT_EN
    logic error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= '0;
            error_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            error_q <= (state_d == S_FAIL);
        end
    end

    assign bus.error = error_q;
`else
    logic unused_cfg;

    assign retry_q    = '0;
    assign bus.error  = 1'b0;
    assign unused_cfg = ^{retry_d, INIT_TIMEOUT[0], MAX_RETRY[0]};
`endif

    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.ddr3_rstn = ddr3_rstn_q;
    assign bus.por_rstn  = por_rstn_q;
    assign bus.hw_rstn   = hw_rstn_q;
    assign bus.ready     = ready_q;
endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// tb_ae350_reset_sequencer: randomized scenarios checked cycle by cycle against an expected
// state timeline derived from the sequencing rules (event edge arithmetic).
module tb_ae350_reset_sequencer;
    localparam int unsigned LS  = 4;
    localparam int unsigned DRC = 8;
    localparam int unsigned PHC = 6;
    localparam int unsigned HHC = 3;
    localparam int unsigned TO  = 20;
    localparam int unsigned MR  = 2;
    localparam int          NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Stimulus plan, expressed as the edge indices at which inputs change.
    int pll_on, ddr_on, pll_gl, ddr_gl, init_on1, init_off1, init_on2, sw_from, sw_to;
    // Expected timeline: from edge tl_e[i] onward the state is tl_s[i] with retry count tl_r[i].
    int tl_e[$];
    int tl_s[$];
    int tl_r[$];

    ae350_reset_sequencer_if bus ();

    ae350_reset_sequencer #(
        .LOCK_STABLE     (LS),
        .DDR_RST_CYCLES  (DRC),
        .POR_HOLD_CYCLES (PHC),
        .HW_HOLD_CYCLES  (HHC),
        .INIT_TIMEOUT    (TO),
        .MAX_RETRY       (MR),
        .CNT_W           (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void tl_clear();
        tl_e.delete();
        tl_s.delete();
        tl_r.delete();
    endfunction

    function automatic void tl_add(input int e, input int s, input int r);
        tl_e.push_back(e);
        tl_s.push_back(s);
        tl_r.push_back(r);
    endfunction

    function automatic void plan_clear();
        pll_on = NEVER; ddr_on = NEVER; pll_gl = NEVER; ddr_gl = NEVER;
        init_on1 = NEVER; init_off1 = NEVER; init_on2 = NEVER;
        sw_from = NEVER; sw_to = NEVER;
    endfunction

    // Expected {state, retry_cnt, ddr3_rstn, por_rstn, hw_rstn, ready, error} after edge e.
    function automatic logic [9:0] exp_vec(input int e);
        int s = 0;
        int r = 0;
        for (int i = 0; i < tl_e.size(); i++) begin
            if (tl_e[i] <= e) begin
                s = tl_s[i];
                r = tl_r[i];
            end
        end
        return {3'(s), 2'(r), (s >= 2 && s <= 5), (s == 4 || s == 5), (s == 5), (s == 5), (s == 6)};
    endfunction

    task automatic drive_edge(input int e);
        bus.pll_lock       = (e >= pll_on) && (e != pll_gl);
        bus.ddr3_lock      = (e >= ddr_on) && (e != ddr_gl);
        bus.ddr3_init_done = ((e >= init_on1) && (e < init_off1)) || (e >= init_on2);
        bus.sw_rst         = (e >= sw_from) && (e < sw_to);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        bus.ddr3_lock = 1'b0;
        bus.ddr3_init_done = 1'b0;
        bus.sw_rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tl_clear();
        tl_add(cyc, 0, 0);
        plan_clear();
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.pll_lock = 1'b1;
            bus.ddr3_lock = 1'b1;
            bus.ddr3_init_done = 1'($urandom_range(0, 1));
            bus.sw_rst = 1'b0;
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            n_cmp++;
            if (got !== 10'b0) begin
                n_bad++;
                $display("FAIL reset edge=%0d got=%b exp=%b", cyc, got, 10'b0);
            end
        end
    endtask

    task automatic test_nominal(input int d, input string tag);
        int b, k, e1, e2, e3, e4, e5, e;
        logic [9:0] got, expv;
        apply_reset();
        b = cyc + 1;
        pll_on = b + int'($urandom_range(0, 3));
        ddr_on = b + int'($urandom_range(0, 3));
        k = imax(pll_on, ddr_on);
        // A DDR lock glitch inside the stability window restarts the lock count.
        if ($urandom_range(0, 1) == 1) begin
            ddr_gl = k + int'($urandom_range(0, LS - 1));
            k = ddr_gl + 1;
        end
        e1 = k + 1 + LS;
        e2 = e1 + DRC;
        init_on1 = e2 + d;
        e3 = imax(e2 + 1, init_on1 + 2);
        e4 = e3 + PHC;
        e5 = e4 + HHC;
        tl_add(e1, 1, 0); tl_add(e2, 2, 0); tl_add(e3, 3, 0); tl_add(e4, 4, 0); tl_add(e5, 5, 0);
        while (cyc < e5 + 4) begin
            @(negedge clk);
            e = cyc + 1;
            drive_edge(e);
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            expv = exp_vec(e);
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL %s edge=%0d got=%b exp=%b", tag, e, got, expv);
            end
        end
    endtask

    task automatic test_lock_glitch();
        int b, e1, e2, e3, e4, e5, g, e1r, e2r, e3r, e4r, e5r, e;
        logic [9:0] got, expv;
        apply_reset();
        b = cyc + 1;
        pll_on = b;
        ddr_on = b;
        e1 = b + 1 + LS;
        e2 = e1 + DRC;
        init_on1 = e2 + int'($urandom_range(0, 12));
        e3 = imax(e2 + 1, init_on1 + 2);
        e4 = e3 + PHC;
        e5 = e4 + HHC;
        g = e5 + int'($urandom_range(1, 5));
        pll_gl = g;
        e1r = g + 2 + LS;
        e2r = e1r + DRC;
        e3r = imax(e2r + 1, init_on1 + 2);
        e4r = e3r + PHC;
        e5r = e4r + HHC;
        tl_add(e1, 1, 0); tl_add(e2, 2, 0); tl_add(e3, 3, 0); tl_add(e4, 4, 0); tl_add(e5, 5, 0);
        tl_add(g + 2, 0, 0);
        tl_add(e1r, 1, 0); tl_add(e2r, 2, 0); tl_add(e3r, 3, 0); tl_add(e4r, 4, 0); tl_add(e5r, 5, 0);
        while (cyc < e5r + 3) begin
            @(negedge clk);
            e = cyc + 1;
            drive_edge(e);
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            expv = exp_vec(e);
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL lock_glitch edge=%0d got=%b exp=%b", e, got, expv);
            end
        end
    endtask

    task automatic test_sw_rst();
        int b, e1, e2, e3, s, e1r, e2r, e3r, e4r, e5r, e;
        logic [9:0] got, expv;
        apply_reset();
        b = cyc + 1;
        pll_on = b;
        ddr_on = b;
        e1 = b + 1 + LS;
        e2 = e1 + DRC;
        init_on1 = e2 + int'($urandom_range(0, 12));
        e3 = imax(e2 + 1, init_on1 + 2);
        s = e3 + int'($urandom_range(1, PHC));
        sw_from = s;
        sw_to = s + 5;
        init_off1 = s;
        e1r = s + 5 + LS - 1;
        e2r = e1r + DRC;
        init_on2 = e2r + int'($urandom_range(0, 8));
        e3r = imax(e2r + 1, init_on2 + 2);
        e4r = e3r + PHC;
        e5r = e4r + HHC;
        tl_add(e1, 1, 0); tl_add(e2, 2, 0); tl_add(e3, 3, 0); tl_add(s, 0, 0);
        tl_add(e1r, 1, 0); tl_add(e2r, 2, 0); tl_add(e3r, 3, 0); tl_add(e4r, 4, 0); tl_add(e5r, 5, 0);
        while (cyc < e5r + 3) begin
            @(negedge clk);
            e = cyc + 1;
            drive_edge(e);
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            expv = exp_vec(e);
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL sw_rst edge=%0d got=%b exp=%b", e, got, expv);
            end
        end
    endtask

`ifdef AE350_RSTSEQ_TIMEOUT_EN
    task automatic test_timeout();
        int b, e1, e2, t1, e2b, t2, f, e1r, e;
        logic [9:0] got, expv;
        apply_reset();
        b = cyc + 1;
        pll_on = b;
        ddr_on = b;
        e1 = b + 1 + LS;
        e2 = e1 + DRC;
        t1 = e2 + TO;
        e2b = t1 + DRC;
        t2 = e2b + TO;
        // Lock glitch while failed must be ignored; only sw_rst leaves FAIL.
        pll_gl = t2 + 2;
        f = t2 + 6 + int'($urandom_range(0, 4));
        sw_from = f;
        sw_to = f + 1;
        e1r = f + LS;
        tl_add(e1, 1, 0); tl_add(e2, 2, 0); tl_add(t1, 1, 1); tl_add(e2b, 2, 1); tl_add(t2, 6, 2);
        tl_add(f, 0, 0); tl_add(e1r, 1, 0); tl_add(e1r + DRC, 2, 0);
        while (cyc < e1r + DRC + 2) begin
            @(negedge clk);
            e = cyc + 1;
            drive_edge(e);
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            expv = exp_vec(e);
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL timeout edge=%0d got=%b exp=%b", e, got, expv);
            end
        end
    endtask
`endif

    task automatic test_async_rst();
        int b, e1, e1r, e;
        logic [9:0] got, expv;
        apply_reset();
        b = cyc + 1;
        pll_on = b;
        ddr_on = b;
        e1 = b + 1 + LS;
        tl_add(e1, 1, 0);
        while (cyc < e1 + 3) begin
            @(negedge clk);
            e = cyc + 1;
            drive_edge(e);
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            expv = exp_vec(e);
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL async_pre edge=%0d got=%b exp=%b", e, got, expv);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
        n_cmp++;
        if (got !== 10'b0) begin
            n_bad++;
            $display("FAIL async_rst_now got=%b exp=%b", got, 10'b0);
        end
        @(posedge clk);
        #1;
        got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
        n_cmp++;
        if (got !== 10'b0) begin
            n_bad++;
            $display("FAIL async_rst_hold got=%b exp=%b", got, 10'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        b = cyc + 1;
        e1r = b + 1 + LS;
        tl_clear();
        tl_add(cyc, 0, 0);
        tl_add(e1r, 1, 0);
        tl_add(e1r + DRC, 2, 0);
        while (cyc < e1r + DRC + 2) begin
            @(negedge clk);
            e = cyc + 1;
            drive_edge(e);
            @(posedge clk);
            #1;
            got = {bus.state, bus.retry_cnt, bus.ddr3_rstn, bus.por_rstn, bus.hw_rstn, bus.ready, bus.error};
            expv = exp_vec(e);
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL async_post edge=%0d got=%b exp=%b", e, got, expv);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        bus.ddr3_lock = 1'b0;
        bus.ddr3_init_done = 1'b0;
        bus.sw_rst = 1'b0;
        plan_clear();
        test_reset();
        test_nominal(10, "nominal");
        test_nominal(int'($urandom_range(0, 12)), "nominal_rand");
        test_lock_glitch();
        test_sw_rst();
`ifdef AE350_RSTSEQ_TIMEOUT_EN
        test_timeout();
`else
        test_nominal(1000, "long_init");
`endif
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
